// File: rtl/rom_image_loader.sv
// Packs a byte stream into little-endian 32-bit words and writes them into the
// program ROM through its debug path. It then reads the image back and compares checksums.
module rom_image_loader #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 13
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_chipselect,
  output logic              rom_write,
  output logic              rom_debugaccess,
  output logic [3:0]        rom_byteenable,
  output logic [31:0]       rom_writedata,
  input  logic [31:0]       rom_readdata,
  output logic              rom_clken,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       checksum
);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_WRITE, S_VERIFY, S_CHECK, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, cur_addr_q;
  logic [CNT_W-1:0]  count_q, remaining_q;
  logic [1:0]        idx_q;
  logic [31:0]       word_q, checksum_q, verify_sum_q, verify_sum_d;
  logic              rd_vld_q, error_q, clken_q;

  function automatic logic [31:0] put_lane(input logic [31:0] word, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] w;
    w = word;
    w[{idx, 3'b000} +: 8] = b;
    return w;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = (word_count == '0) ? S_DONE : S_COLLECT;
      S_COLLECT: if (in_valid && idx_q == 2'd3) state_d = S_WRITE;
      S_WRITE:   state_d = (remaining_q == CNT_W'(1)) ? S_VERIFY : S_COLLECT;
      S_VERIFY:  if (remaining_q == CNT_W'(1)) state_d = S_CHECK;
      S_CHECK:   state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready        = 1'b0;
    rom_chipselect  = 1'b0;
    rom_write       = 1'b0;
    rom_debugaccess = 1'b0;
    rom_byteenable  = 4'h0;
    rom_address     = '0;
    rom_writedata   = '0;
    busy            = 1'b1;
    done            = 1'b0;
    case (state_q)
      S_IDLE:    busy = 1'b0;
      S_COLLECT: in_ready = 1'b1;
      S_WRITE: begin
        rom_chipselect  = 1'b1;
        rom_write       = 1'b1;
        rom_debugaccess = 1'b1;
        rom_byteenable  = 4'hF;
        rom_address     = cur_addr_q;
        rom_writedata   = word_q;
      end
      S_VERIFY: begin
        rom_chipselect = 1'b1;
        rom_byteenable = 4'hF;
        rom_address    = cur_addr_q;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Readback data lags its address by one cycle, so the sum includes the word in flight.
  assign verify_sum_d = verify_sum_q + (rd_vld_q ? rom_readdata : 32'h0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q       <= '0;
      cur_addr_q   <= '0;
      count_q      <= '0;
      remaining_q  <= '0;
      idx_q        <= '0;
      word_q       <= '0;
      checksum_q   <= '0;
      verify_sum_q <= '0;
      rd_vld_q     <= 1'b0;
      error_q      <= 1'b0;
      clken_q      <= 1'b0;
    end else begin
      clken_q      <= 1'b1;
      rd_vld_q     <= (state_q == S_VERIFY);
      verify_sum_q <= verify_sum_d;
      case (state_q)
        S_IDLE: if (start) begin
          base_q      <= base_addr;
          cur_addr_q  <= base_addr;
          count_q     <= word_count;
          remaining_q <= word_count;
          checksum_q  <= '0;
          error_q     <= 1'b0;
          idx_q       <= '0;
        end
        S_COLLECT: if (in_valid) begin
          word_q <= put_lane(word_q, idx_q, in_data);
          idx_q  <= idx_q + 2'd1;
        end
        S_WRITE: begin
          checksum_q <= checksum_q + word_q;
          idx_q      <= '0;
          if (remaining_q == CNT_W'(1)) begin
            cur_addr_q   <= base_q;
            remaining_q  <= count_q;
            verify_sum_q <= '0;
          end else begin
            cur_addr_q  <= cur_addr_q + ADDR_W'(1);
            remaining_q <= remaining_q - CNT_W'(1);
          end
        end
        S_VERIFY: begin
          cur_addr_q  <= cur_addr_q + ADDR_W'(1);
          remaining_q <= remaining_q - CNT_W'(1);
        end
        S_CHECK: error_q <= (verify_sum_d != checksum_q);
        default: ;
      endcase
    end
  end

  assign error     = error_q;
  assign checksum  = checksum_q;
  assign rom_clken = clken_q;

endmodule

// File: tb/tb_rom_image_loader.sv
// Bench for rom_image_loader: a ROM model with optional readback corruption, a bus
// monitor, and a load-level reference model derived from the byte stream.
module tb_rom_image_loader;
  localparam int ADDR_W = 12;
  localparam int CNT_W  = 13;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] rom_address;
  logic              rom_chipselect, rom_write, rom_debugaccess;
  logic [3:0]        rom_byteenable;
  logic [31:0]       rom_writedata;
  logic [31:0]       rom_readdata;
  logic              rom_clken, busy, done, error;
  logic [31:0]       checksum;

  always #5 clk = ~clk;

  rom_image_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .rom_address(rom_address), .rom_chipselect(rom_chipselect),
    .rom_write(rom_write), .rom_debugaccess(rom_debugaccess),
    .rom_byteenable(rom_byteenable), .rom_writedata(rom_writedata),
    .rom_readdata(rom_readdata), .rom_clken(rom_clken), .busy(busy), .done(done),
    .error(error), .checksum(checksum)
  );

  // ROM model: debug writes, registered reads, optional bit-0 flip on one address
  logic [31:0]       mem [0:4095];
  logic              flip_en = 1'b0;
  logic [ADDR_W-1:0] flip_addr = '0;

  always @(posedge clk) begin
    if (rom_chipselect && rom_write && rom_debugaccess) mem[rom_address] <= rom_writedata;
    rom_readdata <= mem[rom_address] ^ {31'b0, (flip_en && rom_address == flip_addr)};
  end

  // Bus monitor, sampled mid-cycle
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];
  logic [ADDR_W-1:0] rd_addr_q[$];
  int                bus_bad = 0;

  always @(negedge clk) begin
    if (rom_chipselect && rom_write) begin
      wr_addr_q.push_back(rom_address);
      wr_data_q.push_back(rom_writedata);
      if (in_ready || rom_byteenable != 4'hF || !rom_debugaccess) bus_bad++;
    end else if (rom_chipselect) begin
      rd_addr_q.push_back(rom_address);
      if (rom_debugaccess || rom_byteenable != 4'hF) bus_bad++;
    end else if (rom_write || rom_debugaccess || rom_byteenable != 4'h0) begin
      bus_bad++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One complete load, checked against what the byte stream implies
  task automatic run_load(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] cnt,
                          input int gap, input bit fixed, input int flip_idx,
                          input bit poke, input bit exp_err);
    logic [7:0]  bytes[$];
    logic [31:0] exp_sum, exp_word;
    int nbytes, ptr, cyc, budget, wbase, rbase, bad0, nbad_a, nbad_d, nwr, nrd;
    bit got_done;
    nbytes = 4 * int'(cnt);
    for (int i = 0; i < nbytes; i++)
      bytes.push_back(fixed ? 8'((i % 4 + 1) * 17) : 8'($urandom));
    flip_en   = (flip_idx >= 0);
    flip_addr = ADDR_W'(int'(base) + flip_idx);
    wbase = wr_addr_q.size();
    rbase = rd_addr_q.size();
    bad0  = bus_bad;

    @(negedge clk);
    start = 1'b1; base_addr = base; word_count = cnt;
    @(negedge clk);
    start = 1'b0; base_addr = ~base; word_count = '1;
    chk("error_cleared_on_start", {31'b0, error}, 0);
    chk("checksum_cleared_on_start", checksum, 0);
    if (cnt == 0) chk("done_one_cycle_after_start", {31'b0, done}, 1);

    ptr = 0; cyc = 0; got_done = 0;
    budget = 30 * int'(cnt) + 40;
    while (!got_done && cyc < budget) begin
      if (done) begin
        got_done = 1;
      end else begin
        in_valid = (ptr < nbytes) && ($urandom_range(99) >= gap);
        in_data  = in_valid ? bytes[ptr] : 8'($urandom);
        if (in_valid && in_ready) ptr++;
        @(negedge clk);
        cyc++;
      end
    end
    in_valid = 1'b0;
    chk("done_within_budget", {31'b0, got_done}, 1);
    chk("bytes_consumed", ptr, nbytes);
    if (got_done) begin
      chk("busy_during_done", {31'b0, busy}, 1);
      chk("error_at_done", {31'b0, error}, {31'b0, exp_err});
      if (poke) begin
        start = 1'b1; base_addr = base + 12'h100; word_count = 13'd1;
      end
      @(negedge clk);
      start = 1'b0;
      chk("done_single_pulse", {31'b0, done}, 0);
      chk("idle_after_done", {31'b0, busy}, 0);
    end

    exp_sum = '0; nbad_a = 0; nbad_d = 0;
    nwr = wr_addr_q.size() - wbase;
    nrd = rd_addr_q.size() - rbase;
    for (int i = 0; i < int'(cnt); i++) begin
      exp_word = {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]};
      exp_sum += exp_word;
      if (i < nwr) begin
        if (wr_addr_q[wbase+i] != ADDR_W'(int'(base) + i)) nbad_a++;
        if (wr_data_q[wbase+i] != exp_word) nbad_d++;
      end
      if (i < nrd && rd_addr_q[rbase+i] != ADDR_W'(int'(base) + i)) nbad_a++;
    end
    chk("write_count", nwr, int'(cnt));
    chk("verify_read_count", nrd, int'(cnt));
    chk("address_mismatches", nbad_a, 0);
    chk("write_data_mismatches", nbad_d, 0);
    chk("bus_protocol_violations", bus_bad - bad0, 0);
    chk("checksum", checksum, exp_sum);
    if (fixed) chk("checksum_fixed_word", checksum, 32'h44332211);
    chk("error_held", {31'b0, error}, {31'b0, exp_err});
    flip_en = 1'b0;
  endtask

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  cnt;
    int                gap;
    bit                fixed;
    int                flip;
    bit                poke;
    bit                exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int ptr, rcnt, rflip;
    vecs[0] = '{12'h010, 13'd1,    0,  1'b1, -1, 1'b0, 1'b0};
    vecs[1] = '{12'h100, 13'd3,    50, 1'b0, -1, 1'b0, 1'b0};
    vecs[2] = '{12'hFFF, 13'd2,    0,  1'b0, -1, 1'b0, 1'b0};
    vecs[3] = '{12'h200, 13'd4,    30, 1'b0, 2,  1'b1, 1'b1};
    vecs[4] = '{12'h050, 13'd0,    0,  1'b0, -1, 1'b0, 1'b0};
    vecs[5] = '{12'hFFE, 13'd5,    20, 1'b0, 0,  1'b0, 1'b1};
    vecs[6] = '{12'h123, 13'd4096, 0,  1'b0, -1, 1'b0, 1'b0};

    reset_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    in_data = '0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_clken", {31'b0, rom_clken}, 0);
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_chipselect", {31'b0, rom_chipselect}, 0);
    chk("reset_checksum", checksum, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("clken_after_reset", {31'b0, rom_clken}, 1);
    chk("idle_in_ready", {31'b0, in_ready}, 0);

    foreach (vecs[k])
      run_load(vecs[k].base, vecs[k].cnt, vecs[k].gap, vecs[k].fixed, vecs[k].flip,
               vecs[k].poke, vecs[k].exp_err);

    // Abort a load mid-word; the next load must use only fresh bytes
    @(negedge clk);
    start = 1'b1; base_addr = 12'h300; word_count = 13'd2;
    @(negedge clk);
    start = 1'b0;
    ptr = 0;
    for (int c = 0; c < 20 && ptr < 2; c++) begin
      in_valid = 1'b1;
      in_data  = 8'hA0 + 8'(ptr);
      if (in_ready) ptr++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bytes_before_abort", ptr, 2);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_in_ready", {31'b0, in_ready}, 0);
    chk("abort_chipselect", {31'b0, rom_chipselect}, 0);
    chk("abort_clken", {31'b0, rom_clken}, 0);
    chk("abort_done", {31'b0, done}, 0);
    chk("abort_checksum", checksum, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_load(12'h020, 13'd1, 0, 1'b0, -1, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      rcnt  = $urandom_range(1, 6);
      rflip = ($urandom_range(3) == 0) ? int'($urandom_range(0, rcnt - 1)) : -1;
      run_load(ADDR_W'($urandom_range(0, 4095)), CNT_W'(rcnt), $urandom_range(0, 60),
               1'b0, rflip, 1'(($urandom_range(1))), rflip >= 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
